// File: rtl/mc_alu_ctrl_fsm_if.sv
// Control bundle between the multi-cycle MIPS32 control FSM (master) and the datapath (slave).
interface mc_alu_ctrl_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       alu_ovf;
  logic       mem_ready;
  logic [3:0] alu_op;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       ill_instr;
  logic       mem_timeout;
  logic       exc_valid;

  modport master (
    input  opcode, funct, alu_zero, alu_ovf, mem_ready,
    output alu_op, alu_src_a, alu_src_b, pc_write, pc_src, ir_write, mem_req, mem_we,
           iord, reg_write, reg_dst, mem_to_reg, ill_instr, mem_timeout, exc_valid
  );

  modport slave (
    output opcode, funct, alu_zero, alu_ovf, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, pc_write, pc_src, ir_write, mem_req, mem_we,
           iord, reg_write, reg_dst, mem_to_reg, ill_instr, mem_timeout, exc_valid
  );
endinterface

// File: rtl/mc_alu_ctrl_fsm.sv
// Multi-cycle MIPS32 control FSM with bounded memory-ready waits.
// Optional feature: define OVF_TRAP_EN to trap signed add/sub overflow into the EXC state.
module mc_alu_ctrl_fsm #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned WCNT_W   = 4
) (
  input logic               clk,
  input logic               rst,
  mc_alu_ctrl_fsm_if.master bus
);

`ifdef OVF_TRAP_EN
  localparam logic OVF_TRAP = 1'b1;
`else
  localparam logic OVF_TRAP = 1'b0;
`endif

  localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(WAIT_MAX);

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,  S_ID  = 4'd1,  S_EXR = 4'd2,  S_EXI = 4'd3,
    S_BR   = 4'd4,  S_J   = 4'd5,  S_MADR = 4'd6, S_MRD = 4'd7,
    S_MWR  = 4'd8,  S_WB  = 4'd9,  S_WBM = 4'd10, S_EXC = 4'd11
  } state_e;

  // R-type funct decode: {legal, alu_op}
  function automatic logic [4:0] r_dec(input logic [5:0] f);
    case (f)
      6'b100000: r_dec = {1'b1, 4'b0100};
      6'b100001: r_dec = {1'b1, 4'b0101};
      6'b100010: r_dec = {1'b1, 4'b0110};
      6'b100011: r_dec = {1'b1, 4'b0111};
      6'b100100: r_dec = {1'b1, 4'b0000};
      6'b100101: r_dec = {1'b1, 4'b0001};
      6'b100110: r_dec = {1'b1, 4'b0010};
      6'b100111: r_dec = {1'b1, 4'b0011};
      6'b101011: r_dec = {1'b1, 4'b1000};
      6'b000000: r_dec = {1'b1, 4'b1010};
      6'b000010: r_dec = {1'b1, 4'b1011};
      default:   r_dec = {1'b0, 4'b0101};
    endcase
  endfunction

  function automatic logic [3:0] i_op(input logic [5:0] opc);
    case (opc)
      OP_ADDI:  i_op = 4'b0100;
      OP_ADDIU: i_op = 4'b0101;
      OP_ANDI:  i_op = 4'b0000;
      OP_ORI:   i_op = 4'b0001;
      OP_XORI:  i_op = 4'b0010;
      OP_LUI:   i_op = 4'b1001;
      OP_SLTIU: i_op = 4'b1000;
      default:  i_op = 4'b0101;
    endcase
  endfunction

  function automatic logic [3:0] b_op(input logic [5:0] opc);
    case (opc)
      OP_BEQ:  b_op = 4'b1100;
      OP_BGTZ: b_op = 4'b1101;
      OP_BLEZ: b_op = 4'b1110;
      OP_BNE:  b_op = 4'b1111;
      default: b_op = 4'b0101;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              wb_rd_q, wb_rd_d;
  logic [4:0]        r_dec_s;
  logic [3:0]        ex_op_s;
  logic              wait_st_s, limit_s, trap_s;

  logic [3:0] alu_op_s;
  logic [1:0] src_a_s, src_b_s, pc_src_s;
  logic       pc_write_s, ir_write_s, mem_req_s, mem_we_s, iord_s;
  logic       reg_write_s, reg_dst_s, mem_to_reg_s, ill_s, tmo_s, exc_s;

  assign r_dec_s   = r_dec(bus.funct);
  assign ex_op_s   = (state_q == S_EXR) ? r_dec_s[3:0] : i_op(bus.opcode);
  assign wait_st_s = (state_q == S_IF) || (state_q == S_MRD) || (state_q == S_MWR);
  // Limit reached only matters when the memory is still not ready this cycle
  assign limit_s   = wait_st_s && !bus.mem_ready && (wcnt_q == WAIT_LIM);
  assign trap_s    = OVF_TRAP && bus.alu_ovf && ((ex_op_s == 4'b0100) || (ex_op_s == 4'b0110));

  // Next-state, writeback-destination and wait-counter logic
  always_comb begin
    state_d = state_q;
    wb_rd_d = wb_rd_q;
    case (state_q)
      S_IF: begin
        if (bus.mem_ready) state_d = S_ID;
        else               state_d = S_IF;
      end
      S_ID: begin
        case (bus.opcode)
          OP_R:                                  state_d = r_dec_s[4] ? S_EXR : S_IF;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
          OP_XORI, OP_LUI, OP_SLTIU:             state_d = S_EXI;
          OP_LW, OP_SW:                          state_d = S_MADR;
          OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:      state_d = S_BR;
          OP_J:                                  state_d = S_J;
          default:                               state_d = S_IF;
        endcase
      end
      S_EXR: begin
        wb_rd_d = 1'b1;
        state_d = trap_s ? S_EXC : S_WB;
      end
      S_EXI: begin
        wb_rd_d = 1'b0;
        state_d = trap_s ? S_EXC : S_WB;
      end
      S_MADR: state_d = (bus.opcode == OP_SW) ? S_MWR : S_MRD;
      S_MRD: begin
        if (bus.mem_ready)  state_d = S_WBM;
        else if (limit_s)   state_d = S_IF;
        else                state_d = S_MRD;
      end
      S_MWR: begin
        if (bus.mem_ready || limit_s) state_d = S_IF;
        else                          state_d = S_MWR;
      end
      default: state_d = S_IF;
    endcase

    if ((state_d != state_q) || limit_s)        wcnt_d = '0;
    else if (wait_st_s && !bus.mem_ready)       wcnt_d = wcnt_q + {{(WCNT_W-1){1'b0}}, 1'b1};
    else                                        wcnt_d = wcnt_q;
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      wcnt_q  <= '0;
      wb_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      wb_rd_q <= wb_rd_d;
    end
  end

  // State decode of the control word; reset holds everything at the idle pattern
  always_comb begin
    alu_op_s     = 4'b0101;
    src_a_s      = 2'b00;
    src_b_s      = 2'b00;
    pc_src_s     = 2'b00;
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    iord_s       = 1'b0;
    reg_write_s  = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    ill_s        = 1'b0;
    tmo_s        = 1'b0;
    exc_s        = 1'b0;
    if (rst) begin
      alu_op_s = 4'b0101;
    end else begin
      case (state_q)
        S_IF: begin
          mem_req_s  = 1'b1;
          src_b_s    = 2'b01;
          ir_write_s = bus.mem_ready;
          pc_write_s = bus.mem_ready;
          tmo_s      = limit_s;
        end
        S_ID: begin
          src_b_s = 2'b11;
          ill_s   = (state_d == S_IF);
        end
        S_EXR: begin
          alu_op_s = ex_op_s;
          src_a_s  = (ex_op_s[3:1] == 3'b101) ? 2'b10 : 2'b01;
        end
        S_EXI: begin
          alu_op_s = ex_op_s;
          src_a_s  = 2'b01;
          src_b_s  = 2'b10;
        end
        S_BR: begin
          alu_op_s   = b_op(bus.opcode);
          src_a_s    = 2'b01;
          pc_write_s = bus.alu_zero;
          pc_src_s   = 2'b01;
        end
        S_J: begin
          pc_write_s = 1'b1;
          pc_src_s   = 2'b10;
        end
        S_MADR: begin
          src_a_s = 2'b01;
          src_b_s = 2'b10;
        end
        S_MRD: begin
          mem_req_s = 1'b1;
          iord_s    = 1'b1;
          tmo_s     = limit_s;
        end
        S_MWR: begin
          mem_req_s = 1'b1;
          mem_we_s  = 1'b1;
          iord_s    = 1'b1;
          tmo_s     = limit_s;
        end
        S_WB: begin
          reg_write_s = 1'b1;
          reg_dst_s   = wb_rd_q;
        end
        S_WBM: begin
          reg_write_s  = 1'b1;
          mem_to_reg_s = 1'b1;
        end
        S_EXC: begin
          exc_s      = OVF_TRAP;
          pc_write_s = 1'b1;
          pc_src_s   = 2'b11;
        end
        default: alu_op_s = 4'b0101;
      endcase
    end
  end

  assign bus.alu_op      = alu_op_s;
  assign bus.alu_src_a   = src_a_s;
  assign bus.alu_src_b   = src_b_s;
  assign bus.pc_write    = pc_write_s;
  assign bus.pc_src      = pc_src_s;
  assign bus.ir_write    = ir_write_s;
  assign bus.mem_req     = mem_req_s;
  assign bus.mem_we      = mem_we_s;
  assign bus.iord        = iord_s;
  assign bus.reg_write   = reg_write_s;
  assign bus.reg_dst     = reg_dst_s;
  assign bus.mem_to_reg  = mem_to_reg_s;
  assign bus.ill_instr   = ill_s;
  assign bus.mem_timeout = tmo_s;
  assign bus.exc_valid   = exc_s;

endmodule

// File: tb/tb_mc_alu_ctrl_fsm.sv
// Directed bench: instruction-level timeline model builds the expected control word per cycle.
module tb_mc_alu_ctrl_fsm;
  localparam int WAIT_MAX = 15;
`ifdef OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] JJ = 6'b000010;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       ill;
    logic       tmo;
    logic       exc;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic       rdy;
    logic [5:0] opc;
    logic [5:0] fn;
    logic       zero;
    logic       ovf;
    out_t       exp;
  } ent_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  ent_t q[$];
  logic [3:0] r_tab [logic [5:0]];
  logic [3:0] i_tab [logic [5:0]];
  logic [3:0] b_tab [logic [5:0]];
  logic [5:0] cur_opc, cur_fn;
  logic       cur_zero, cur_ovf;

  mc_alu_ctrl_fsm_if bus();

  mc_alu_ctrl_fsm #(.WAIT_MAX(15), .WCNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t idle();
    out_t o;
    o = '0;
    o.alu_op = 4'b0101;
    return o;
  endfunction

  function automatic out_t mem_o(input logic [5:0] opc);
    out_t o;
    o = idle();
    o.mem_req = 1'b1;
    o.iord    = 1'b1;
    o.mem_we  = (opc == SW);
    return o;
  endfunction

  function automatic out_t sample();
    out_t a;
    a.alu_op     = bus.alu_op;
    a.src_a      = bus.alu_src_a;
    a.src_b      = bus.alu_src_b;
    a.pc_write   = bus.pc_write;
    a.pc_src     = bus.pc_src;
    a.ir_write   = bus.ir_write;
    a.mem_req    = bus.mem_req;
    a.mem_we     = bus.mem_we;
    a.iord       = bus.iord;
    a.reg_write  = bus.reg_write;
    a.reg_dst    = bus.reg_dst;
    a.mem_to_reg = bus.mem_to_reg;
    a.ill        = bus.ill_instr;
    a.tmo        = bus.mem_timeout;
    a.exc        = bus.exc_valid;
    return a;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic push(input logic r, input logic rdy, input out_t o);
    ent_t e;
    e.rst  = r;
    e.rdy  = rdy;
    e.opc  = cur_opc;
    e.fn   = cur_fn;
    e.zero = cur_zero;
    e.ovf  = cur_ovf;
    e.exp  = o;
    q.push_back(e);
  endtask

  task automatic writeback(input logic [3:0] op, input logic rd);
    out_t o;
    o = idle();
    if (TRAP && cur_ovf && (op == 4'b0100 || op == 4'b0110)) begin
      o.exc = 1'b1; o.pc_write = 1'b1; o.pc_src = 2'b11;
    end else begin
      o.reg_write = 1'b1; o.reg_dst = rd;
    end
    push(1'b0, 1'b1, o);
  endtask

  // Timeline of one instruction: fetch waits, decode, execute, memory waits, writeback
  task automatic instr(input logic [5:0] opc, input logic [5:0] fn, input logic zero, input logic ovf,
                       input int if_wait, input int mem_wait, input bit rst_mem);
    out_t o;
    logic [3:0] op;
    bit legal;
    cur_opc = opc; cur_fn = fn; cur_zero = zero; cur_ovf = ovf;
    for (int k = 0; k < if_wait && k <= WAIT_MAX; k++) begin
      o = idle(); o.mem_req = 1'b1; o.src_b = 2'b01; o.tmo = (k == WAIT_MAX);
      push(1'b0, 1'b0, o);
    end
    if (if_wait > WAIT_MAX) return;
    o = idle(); o.mem_req = 1'b1; o.src_b = 2'b01; o.ir_write = 1'b1; o.pc_write = 1'b1;
    push(1'b0, 1'b1, o);
    if (opc == 6'b000000) legal = (r_tab.exists(fn) != 0);
    else legal = (i_tab.exists(opc) != 0) || (b_tab.exists(opc) != 0) || opc == LW || opc == SW || opc == JJ;
    o = idle(); o.src_b = 2'b11; o.ill = !legal;
    push(1'b0, 1'b1, o);
    if (!legal) return;
    if (opc == 6'b000000) begin
      op = r_tab[fn];
      o = idle(); o.alu_op = op; o.src_a = (fn == 6'b000000 || fn == 6'b000010) ? 2'b10 : 2'b01;
      push(1'b0, 1'b1, o);
      writeback(op, 1'b1);
    end else if (i_tab.exists(opc) != 0) begin
      op = i_tab[opc];
      o = idle(); o.alu_op = op; o.src_a = 2'b01; o.src_b = 2'b10;
      push(1'b0, 1'b1, o);
      writeback(op, 1'b0);
    end else if (b_tab.exists(opc) != 0) begin
      o = idle(); o.alu_op = b_tab[opc]; o.src_a = 2'b01; o.pc_write = zero; o.pc_src = 2'b01;
      push(1'b0, 1'b1, o);
    end else if (opc == JJ) begin
      o = idle(); o.pc_write = 1'b1; o.pc_src = 2'b10;
      push(1'b0, 1'b1, o);
    end else begin
      o = idle(); o.src_a = 2'b01; o.src_b = 2'b10;
      push(1'b0, 1'b1, o);
      for (int k = 0; k < mem_wait && k <= WAIT_MAX; k++) begin
        o = mem_o(opc); o.tmo = (k == WAIT_MAX);
        push(1'b0, 1'b0, o);
      end
      if (mem_wait > WAIT_MAX) return;
      if (rst_mem) begin
        push(1'b1, 1'b0, idle());
        return;
      end
      push(1'b0, 1'b1, mem_o(opc));
      if (opc == LW) begin
        o = idle(); o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
        push(1'b0, 1'b1, o);
      end
    end
  endtask

  task automatic run_all();
    ent_t e;
    int   idx;
    idx = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      rst           = e.rst;
      bus.mem_ready = e.rdy;
      bus.opcode    = e.opc;
      bus.funct     = e.fn;
      bus.alu_zero  = e.zero;
      bus.alu_ovf   = e.ovf;
      @(negedge clk);
      check($sformatf("cycle%0d", idx), {11'd0, sample()}, {11'd0, e.exp});
      idx++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int b;
    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    bus.opcode = 6'b0; bus.funct = 6'b0; bus.alu_zero = 1'b0; bus.alu_ovf = 1'b0; bus.mem_ready = 1'b1;
    r_tab[6'b100000] = 4'b0100; r_tab[6'b100001] = 4'b0101; r_tab[6'b100010] = 4'b0110;
    r_tab[6'b100011] = 4'b0111; r_tab[6'b100100] = 4'b0000; r_tab[6'b100101] = 4'b0001;
    r_tab[6'b100110] = 4'b0010; r_tab[6'b100111] = 4'b0011; r_tab[6'b101011] = 4'b1000;
    r_tab[6'b000000] = 4'b1010; r_tab[6'b000010] = 4'b1011;
    i_tab[6'b001000] = 4'b0100; i_tab[6'b001001] = 4'b0101; i_tab[6'b001100] = 4'b0000;
    i_tab[6'b001101] = 4'b0001; i_tab[6'b001110] = 4'b0010; i_tab[6'b001111] = 4'b1001;
    i_tab[6'b001011] = 4'b1000;
    b_tab[6'b000100] = 4'b1100; b_tab[6'b000111] = 4'b1101; b_tab[6'b000110] = 4'b1110;
    b_tab[6'b000101] = 4'b1111;

    cur_opc = 6'b0; cur_fn = 6'b100001; cur_zero = 1'b0; cur_ovf = 1'b0;
    push(1'b1, 1'b1, idle());
    push(1'b1, 1'b1, idle());
    instr(6'b000000, 6'b100001, 1'b0, 1'b0, 0, 0, 1'b0);
    check("len_rst_addu", 32'(q.size()), 32'd6);
    check("addu_op", {28'd0, q[4].exp.alu_op}, 32'h5);
    check("addu_wb", {30'd0, q[5].exp.reg_write, q[5].exp.reg_dst}, 32'h3);

    b = q.size(); instr(6'b000100, 6'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    check("len_beq", 32'(q.size() - b), 32'd3);
    check("beq_br", {25'd0, q[b+2].exp.alu_op, q[b+2].exp.pc_write, q[b+2].exp.pc_src}, {25'd0, 4'b1100, 1'b1, 2'b01});
    b = q.size(); instr(6'b000101, 6'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    check("bne_br", {27'd0, q[b+2].exp.alu_op, q[b+2].exp.pc_write}, {27'd0, 4'b1111, 1'b0});
    instr(6'b000110, 6'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    instr(6'b000111, 6'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    b = q.size(); instr(JJ, 6'b0, 1'b0, 1'b0, 1, 0, 1'b0);
    check("len_j_wait1", 32'(q.size() - b), 32'd4);

    b = q.size(); instr(LW, 6'b0, 1'b0, 1'b0, 0, 3, 1'b0);
    check("len_lw_wait3", 32'(q.size() - b), 32'd8);
    b = q.size(); instr(SW, 6'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    check("len_sw", 32'(q.size() - b), 32'd4);

    instr(6'b000000, 6'b100000, 1'b0, 1'b1, 0, 0, 1'b0);
    instr(6'b000000, 6'b100010, 1'b0, 1'b1, 0, 0, 1'b0);
    instr(6'b000000, 6'b100100, 1'b0, 1'b1, 0, 0, 1'b0);
    instr(6'b001000, 6'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    instr(6'b001001, 6'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    instr(6'b000000, 6'b000000, 1'b0, 1'b0, 0, 0, 1'b0);
    instr(6'b000000, 6'b000010, 1'b0, 1'b0, 0, 0, 1'b0);
    instr(6'b000000, 6'b100111, 1'b0, 1'b0, 0, 0, 1'b0);
    instr(6'b000000, 6'b100110, 1'b0, 1'b0, 0, 0, 1'b0);
    instr(6'b000000, 6'b100101, 1'b0, 1'b0, 0, 0, 1'b0);
    instr(6'b000000, 6'b100011, 1'b0, 1'b0, 0, 0, 1'b0);
    instr(6'b000000, 6'b101011, 1'b0, 1'b0, 0, 0, 1'b0);
    b = q.size(); instr(6'b001101, 6'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    check("len_ori", 32'(q.size() - b), 32'd4);
    instr(6'b001111, 6'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    instr(6'b001011, 6'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    instr(6'b001110, 6'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    instr(6'b001100, 6'b0, 1'b0, 1'b0, 0, 0, 1'b0);

    b = q.size(); instr(6'b000000, 6'b100001, 1'b0, 1'b0, 16, 0, 1'b0);
    check("len_if_timeout", 32'(q.size() - b), 32'd16);
    check("if_timeout_pulse", {31'd0, q[b+15].exp.tmo}, 32'd1);
    instr(6'b000000, 6'b100001, 1'b0, 1'b0, 0, 0, 1'b0);
    b = q.size(); instr(SW, 6'b0, 1'b0, 1'b0, 0, 15, 1'b0);
    check("len_sw_wait15", 32'(q.size() - b), 32'd19);
    instr(LW, 6'b0, 1'b0, 1'b0, 0, 16, 1'b0);

    b = q.size(); instr(6'b111111, 6'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    check("ill_pulse", {31'd0, q[b+1].exp.ill}, 32'd1);
    instr(6'b000000, 6'b111111, 1'b0, 1'b0, 0, 0, 1'b0);
    instr(SW, 6'b0, 1'b0, 1'b0, 0, 2, 1'b1);
    instr(6'b000000, 6'b100001, 1'b0, 1'b0, 2, 0, 1'b0);

    run_all();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
